// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl
//   Multiplexed seven-segment display controller with built-in hex decoding.
//   Scans DIGITS digits (sel[0] = rightmost), one slot of 2^SCAN_DIV_BITS
//   clocks per digit. All display inputs are latched into shadow registers
//   only at a frame boundary, so a frame never mixes old and new data.
//   Features: per-digit blank/blink, leading-zero suppression, PWM brightness
//   and a one-cycle dead time at the start of every slot against ghosting.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   value       in   4*DIGITS hex nibbles, nibble i drives digit i
//   dot         in   DIGITS decimal point enables (active high)
//   blank_mask  in   DIGITS force-off per digit (active high)
//   blink_mask  in   DIGITS blink enable per digit (active high)
//   lz_blank    in   leading-zero suppression enable
//   brightness  in   BRIGHT_BITS duty control, all-ones = full on
//   update      in   one-cycle strobe requesting shadow capture
//   frame_tick  out  one-cycle pulse at each frame boundary
//   sel         out  DIGITS digit selects (active low)
//   seg_led     out  segments (active low), bit7 = dp, bits6:0 = gfedcba
module seg_display_ctrl #(
    parameter int unsigned DIGITS        = 6,
    parameter int unsigned SCAN_DIV_BITS = 16,
    parameter int unsigned BRIGHT_BITS   = 3,
    parameter int unsigned BLINK_FRAMES  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [4*DIGITS-1:0]      value,
    input  logic [DIGITS-1:0]        dot,
    input  logic [DIGITS-1:0]        blank_mask,
    input  logic [DIGITS-1:0]        blink_mask,
    input  logic                     lz_blank,
    input  logic [BRIGHT_BITS-1:0]   brightness,
    input  logic                     update,
    output logic                     frame_tick,
    output logic [DIGITS-1:0]        sel,
    output logic [7:0]               seg_led
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    logic [SCAN_DIV_BITS-1:0] slot_q, slot_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [BLK_W-1:0]         blink_cnt_q, blink_cnt_d;
    logic                     blink_phase_q, blink_phase_d;
    logic                     pend_q, pend_d;

    logic [4*DIGITS-1:0]      val_q, val_d;
    logic [DIGITS-1:0]        dot_q, dot_d;
    logic [DIGITS-1:0]        blank_q, blank_d;
    logic [DIGITS-1:0]        blinkm_q, blinkm_d;
    logic                     lz_q, lz_d;
    logic [BRIGHT_BITS-1:0]   bright_q, bright_d;

    logic [DIGITS-1:0]        sel_q, sel_d;
    logic [7:0]               seg_q, seg_d;
    logic                     tick_q, tick_d;

    logic                     slot_end, last_digit, boundary, capture;
    logic                     hi_nz;
    logic [DIGITS-1:0]        lz_sup;
    logic [3:0]               nib;
    logic                     digit_on;

    // Counters, blink and shadow capture
    always_comb begin
        slot_end      = &slot_q;
        last_digit    = (idx_q == IDX_W'(DIGITS - 1));
        boundary      = slot_end && last_digit;
        capture       = boundary && (pend_q || update);

        slot_d        = slot_q + 1'b1;
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        pend_d        = capture ? 1'b0 : (pend_q || update);

        val_d    = val_q;
        dot_d    = dot_q;
        blank_d  = blank_q;
        blinkm_d = blinkm_q;
        lz_d     = lz_q;
        bright_d = bright_q;

        if (slot_end) begin
            idx_d = last_digit ? '0 : idx_q + 1'b1;
        end

        if (boundary) begin
            if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        if (capture) begin
            val_d    = value;
            dot_d    = dot;
            blank_d  = blank_mask;
            blinkm_d = blink_mask;
            lz_d     = lz_blank;
            bright_d = brightness;
        end
    end

    // Leading-zero suppression: walk from the top digit down; a digit is
    // suppressed while nothing non-zero (nibble or dot) has been seen yet.
    always_comb begin
        hi_nz  = 1'b0;
        lz_sup = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            hi_nz = hi_nz || (val_q[4*(DIGITS-1-k) +: 4] != 4'h0) || dot_q[DIGITS-1-k];
            lz_sup[DIGITS-1-k] = lz_q && !hi_nz && ((DIGITS - 1 - k) != 0);
        end
    end

    // Output decode from current counter state; registered below
    always_comb begin
        nib      = val_q[4*idx_q +: 4];
        digit_on = !blank_q[idx_q]
                && !lz_sup[idx_q]
                && !(blinkm_q[idx_q] && !blink_phase_q)
                && (slot_q != '0)
                && (slot_q[SCAN_DIV_BITS-1 -: BRIGHT_BITS] <= bright_q);

        sel_d  = '1;
        seg_d  = 8'hFF;
        tick_d = boundary;
        if (digit_on) begin
            sel_d = ~(DIGITS'(1) << idx_q);
            seg_d = {~dot_q[idx_q], hex7(nib)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q        <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            pend_q        <= 1'b0;
            val_q         <= '0;
            dot_q         <= '0;
            blank_q       <= '0;
            blinkm_q      <= '0;
            lz_q          <= 1'b0;
            bright_q      <= '0;
            sel_q         <= '1;
            seg_q         <= 8'hFF;
            tick_q        <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pend_q        <= pend_d;
            val_q         <= val_d;
            dot_q         <= dot_d;
            blank_q       <= blank_d;
            blinkm_q      <= blinkm_d;
            lz_q          <= lz_d;
            bright_q      <= bright_d;
            sel_q         <= sel_d;
            seg_q         <= seg_d;
            tick_q        <= tick_d;
        end
    end

    assign sel        = sel_q;
    assign seg_led    = seg_q;
    assign frame_tick = tick_q;

endmodule
